tinyqv_data_router: RTL and testbench
=====================================

// Module: tinyqv_data_router
// PURPOSE
//  Parametrised data-port router between the TinyQV CPU data interface and NUM_CH
//  downstream targets (ch 0 = QSPI memory controller, others = peripheral buses).
//  Decodes the region index from the address and locks the route for the whole
//  transaction. Adds a per-transaction timeout and an unmapped-region response,
//  both of which set sticky error status. Sits between the CPU and the memory
//  controller / peripheral fabric in the top-level wrapper.
// PARAMETERS
//  NUM_CH     4    number of target channels, 1..8; region index = addr[27:25]
//  TIMEOUT    255  max ACTIVE cycles before forced completion; 0 = timeout disabled
//  ERR_DATA   32'h0  read data returned on timeout or unmapped access
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous reset, active high
//  cpu_addr       in   28         CPU data address
//  cpu_write_n    in   2          11 none, 00 8b, 01 16b, 10 32b
//  cpu_read_n     in   2          same encoding as cpu_write_n
//  cpu_read_complete in 1         CPU has consumed read data
//  cpu_data_out   in   32         write data
//  cpu_data_ready out  1          transaction complete to CPU
//  cpu_data_in    out  32         read data to CPU
//  ch_addr        out  28         shared address to all channels (= cpu_addr)
//  ch_data_out    out  32         shared write data (= cpu_data_out)
//  ch_write_n     out  2*NUM_CH   per-channel write_n, ch i at [2i+1:2i]
//  ch_read_n      out  2*NUM_CH   per-channel read_n
//  ch_read_complete out NUM_CH    per-channel read_complete
//  ch_ready       in   NUM_CH     per-channel data_ready
//  ch_data_in     in   32*NUM_CH  per-channel read data, ch i at [32i+31:32i]
//  err_clr        in   1          clears err_timeout, err_unmapped, err_addr
//  err_timeout    out  1          sticky: a transaction timed out
//  err_unmapped   out  1          sticky: access to region >= NUM_CH
//  err_addr       out  28         address of the most recent erroring transaction
// BEHAVIOUR
//  - req = (cpu_write_n != 2'b11) | (cpu_read_n != 2'b11).
//  - FSM states IDLE, ACTIVE, UNMAP. Reset -> IDLE; sel = 0; count = 0; all errors 0,
//    err_addr = 0; all ch_write_n/ch_read_n = 11; ch_read_complete = 0.
//  - IDLE: route = addr[27:25] decoded combinationally. If req and index < NUM_CH:
//    drive that channel's write_n/read_n in the same cycle, latch sel = index;
//    if its ch_ready is also high, complete this cycle (stay IDLE), else -> ACTIVE.
//    If req and index >= NUM_CH: -> UNMAP, no channel driven.
//  - ACTIVE: route uses latched sel only (address changes ignored). count += 1 per cycle.
//    cpu_data_ready = ch_ready[sel], cpu_data_in = ch_data_in[sel]; on ready -> IDLE, count = 0.
//    If TIMEOUT != 0 and count == TIMEOUT-1 with ch_ready[sel] low: cpu_data_ready = 1,
//    cpu_data_in = ERR_DATA, channel write_n/read_n forced 11 in that cycle,
//    err_timeout = 1, err_addr = cpu_addr, -> IDLE. ch_ready and timeout in the same
//    cycle: ch_ready wins, no error.
//  - UNMAP: one cycle: cpu_data_ready = 1, cpu_data_in = ERR_DATA, err_unmapped = 1,
//    err_addr = cpu_addr, -> IDLE. Unmapped access thus completes 1 cycle after request.
//  - cpu_data_ready is 0 and cpu_data_in = ERR_DATA whenever no completion applies.
//  - cpu_read_complete routed to ch_read_complete[sel] (sel retained after return to IDLE).
//  - Non-selected channels always see 11/11/0.
//  - err_clr and a new error in the same cycle: the new error wins (flag set, addr updated).
//  - count width = $clog2(TIMEOUT+1); saturates, never wraps.
//  - rst mid-transaction: immediate return to IDLE, outputs to reset values, no
//    completion pulse to the CPU.
// TESTING
//  1 Read 32b at addr 0x4000010 (region 2), ch_ready[2] after 3 cycles with data
//    0x12345678 -> only ch 2 read_n = 10; cpu_data_ready 1 cycle, data 0x12345678.
//  2 Write at region 1, addr bits changed to region 3 in cycle 2 -> ch 1 stays
//    selected until ch_ready[1]; ch 3 never driven.
//  3 TIMEOUT=8, region 1, ch_ready never -> cpu_data_ready on 8th ACTIVE cycle,
//    data ERR_DATA, err_timeout = 1, err_addr = request addr; err_clr clears both.
//  4 NUM_CH=4, read addr 0xA000000 (region 5) -> no channel driven, ready next
//    cycle, data ERR_DATA, err_unmapped = 1.
//  5 ch_ready asserted exactly on timeout cycle -> channel data returned, err_timeout 0.
//  6 rst asserted in ACTIVE cycle 2 -> next cycle IDLE, all ch_*_n = 11, no ready pulse.

Source files
------------

// File: rtl/tinyqv_data_router.sv
// TinyQV data-port router: decodes addr[27:25] into one of NUM_CH targets, locks the
// route for the transaction, and adds timeout / unmapped-region error responses.
module tinyqv_data_router #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'h0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [27:0]           i_cpu_addr,
    input  logic [1:0]            i_cpu_write_n,
    input  logic [1:0]            i_cpu_read_n,
    input  logic                  i_cpu_read_complete,
    input  logic [31:0]           i_cpu_data_out,
    output logic                  o_cpu_data_ready,
    output logic [31:0]           o_cpu_data_in,
    output logic [27:0]           o_ch_addr,
    output logic [31:0]           o_ch_data_out,
    output logic [2*NUM_CH-1:0]   o_ch_write_n,
    output logic [2*NUM_CH-1:0]   o_ch_read_n,
    output logic [NUM_CH-1:0]     o_ch_read_complete,
    input  logic [NUM_CH-1:0]     i_ch_ready,
    input  logic [32*NUM_CH-1:0]  i_ch_data_in,
    input  logic                  i_err_clr,
    output logic                  o_err_timeout,
    output logic                  o_err_unmapped,
    output logic [27:0]           o_err_addr
);

    localparam int unsigned CNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned MAX_CH = 8;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_UNMAP} state_t;

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_sel, w_sel_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic               r_err_timeout, w_err_timeout_nxt;
    logic               r_err_unmapped, w_err_unmapped_nxt;
    logic [27:0]        r_err_addr, w_err_addr_nxt;

    logic [2:0]         w_idx;
    logic               w_req;
    logic               w_mapped;
    logic               w_drv_en;
    logic [2:0]         w_drv_ch;
    logic               w_ready;
    logic [31:0]        w_rdata;
    logic               w_to_err;
    logic               w_un_err;
    logic [MAX_CH-1:0]  w_ch_ready;
    logic [31:0]        w_ch_data [MAX_CH];

    assign w_idx    = i_cpu_addr[27:25];
    assign w_req    = (i_cpu_write_n != 2'b11) || (i_cpu_read_n != 2'b11);
    assign w_mapped = ({1'b0, w_idx} < 4'(NUM_CH));

    // Pad channel inputs to 8 entries so a 3-bit index always selects cleanly
    for (genvar g = 0; g < NUM_CH; g++) begin : g_in
        assign w_ch_ready[g] = i_ch_ready[g];
        assign w_ch_data[g]  = i_ch_data_in[32*g +: 32];
    end
    for (genvar g = NUM_CH; g < MAX_CH; g++) begin : g_pad
        assign w_ch_ready[g] = 1'b0;
        assign w_ch_data[g]  = ERR_DATA;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_sel          <= '0;
            r_count        <= '0;
            r_err_timeout  <= 1'b0;
            r_err_unmapped <= 1'b0;
            r_err_addr     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_sel          <= w_sel_nxt;
            r_count        <= w_count_nxt;
            r_err_timeout  <= w_err_timeout_nxt;
            r_err_unmapped <= w_err_unmapped_nxt;
            r_err_addr     <= w_err_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_count_nxt = '0;
        w_drv_en    = 1'b0;
        w_drv_ch    = r_sel;
        w_ready     = 1'b0;
        w_rdata     = ERR_DATA;
        w_to_err    = 1'b0;
        w_un_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_mapped) begin
                        w_drv_en  = 1'b1;
                        w_drv_ch  = w_idx;
                        w_sel_nxt = w_idx;
                        if (w_ch_ready[w_idx]) begin
                            w_ready = 1'b1;
                            w_rdata = w_ch_data[w_idx];
                        end else begin
                            w_state_nxt = S_ACTIVE;
                        end
                    end else begin
                        w_state_nxt = S_UNMAP;
                    end
                end
            end
            S_ACTIVE: begin
                w_drv_en    = 1'b1;
                w_count_nxt = (r_count == '1) ? r_count : r_count + CNT_W'(1);
                if (w_ch_ready[r_sel]) begin
                    // A ready arriving on the timeout cycle is a normal completion
                    w_ready     = 1'b1;
                    w_rdata     = w_ch_data[r_sel];
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end else if (TIMEOUT != 0 && r_count == CNT_W'(TIMEOUT - 1)) begin
                    w_ready     = 1'b1;
                    w_drv_en    = 1'b0;
                    w_to_err    = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end
            end
            S_UNMAP: begin
                w_ready     = 1'b1;
                w_un_err    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Clear first so an error raised in the same cycle survives it
    always_comb begin
        w_err_timeout_nxt  = r_err_timeout;
        w_err_unmapped_nxt = r_err_unmapped;
        w_err_addr_nxt     = r_err_addr;
        if (i_err_clr) begin
            w_err_timeout_nxt  = 1'b0;
            w_err_unmapped_nxt = 1'b0;
            w_err_addr_nxt     = '0;
        end
        if (w_to_err) begin
            w_err_timeout_nxt = 1'b1;
            w_err_addr_nxt    = i_cpu_addr;
        end
        if (w_un_err) begin
            w_err_unmapped_nxt = 1'b1;
            w_err_addr_nxt     = i_cpu_addr;
        end
    end

    // Reset forces the CPU/channel handshake outputs to idle immediately
    assign o_cpu_data_ready = w_ready && !i_rst;
    assign o_cpu_data_in    = i_rst ? ERR_DATA : w_rdata;
    assign o_ch_addr        = i_cpu_addr;
    assign o_ch_data_out    = i_cpu_data_out;
    assign o_err_timeout    = r_err_timeout;
    assign o_err_unmapped   = r_err_unmapped;
    assign o_err_addr       = r_err_addr;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        logic w_hit;
        assign w_hit = w_drv_en && !i_rst && (w_drv_ch == 3'(g));
        assign o_ch_write_n[2*g +: 2]  = w_hit ? i_cpu_write_n : 2'b11;
        assign o_ch_read_n[2*g +: 2]   = w_hit ? i_cpu_read_n : 2'b11;
        assign o_ch_read_complete[g]   = !i_rst && (r_sel == 3'(g)) && i_cpu_read_complete;
    end

endmodule

// File: tb/tb_tinyqv_data_router.sv
// Randomized bench for tinyqv_data_router against a transaction-level reference model.
module tb_tinyqv_data_router;

    localparam int          NCH  = 4;
    localparam int          TO   = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [27:0]          cpu_addr;
    logic [1:0]           cpu_write_n, cpu_read_n;
    logic                 cpu_read_complete;
    logic [31:0]          cpu_data_out;
    logic                 cpu_data_ready;
    logic [31:0]          cpu_data_in;
    logic [27:0]          ch_addr;
    logic [31:0]          ch_data_out;
    logic [2*NCH-1:0]     ch_write_n, ch_read_n;
    logic [NCH-1:0]       ch_read_complete;
    logic [NCH-1:0]       ch_ready;
    logic [32*NCH-1:0]    ch_data_in;
    logic                 err_clr;
    logic                 err_timeout, err_unmapped;
    logic [27:0]          err_addr;

    int n_chk = 0;
    int n_bad = 0;

    // Reference state: sticky flags, error address and the last routed channel
    bit          m_to, m_un;
    logic [27:0] m_addr;
    int          m_sel;

    tinyqv_data_router #(.NUM_CH(NCH), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_addr(cpu_addr), .i_cpu_write_n(cpu_write_n), .i_cpu_read_n(cpu_read_n),
        .i_cpu_read_complete(cpu_read_complete), .i_cpu_data_out(cpu_data_out),
        .o_cpu_data_ready(cpu_data_ready), .o_cpu_data_in(cpu_data_in),
        .o_ch_addr(ch_addr), .o_ch_data_out(ch_data_out),
        .o_ch_write_n(ch_write_n), .o_ch_read_n(ch_read_n),
        .o_ch_read_complete(ch_read_complete), .i_ch_ready(ch_ready),
        .i_ch_data_in(ch_data_in), .i_err_clr(err_clr),
        .o_err_timeout(err_timeout), .o_err_unmapped(err_unmapped), .o_err_addr(err_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic e_rdy, input logic [31:0] e_data,
                             input logic [7:0] e_wn, input logic [7:0] e_rn,
                             input logic [3:0] e_rc);
        check("ready", 32'(cpu_data_ready), 32'(e_rdy));
        check("rdata", cpu_data_in, e_data);
        check("ch_write_n", 32'(ch_write_n), 32'(e_wn));
        check("ch_read_n", 32'(ch_read_n), 32'(e_rn));
        check("ch_read_complete", 32'(ch_read_complete), 32'(e_rc));
        check("ch_addr", 32'(ch_addr), 32'(cpu_addr));
        check("ch_data_out", ch_data_out, cpu_data_out);
        check("err_timeout", 32'(err_timeout), 32'(m_to));
        check("err_unmapped", 32'(err_unmapped), 32'(m_un));
        check("err_addr", 32'(err_addr), 32'(m_addr));
    endtask

    task automatic noise();
        for (int k = 0; k < NCH; k++) begin
            ch_ready[k] = 1'($urandom_range(0, 1));
            ch_data_in[32*k +: 32] = $urandom;
        end
        cpu_read_complete = 1'($urandom_range(0, 1));
        cpu_data_out = $urandom;
    endtask

    task automatic clear_model();
        m_to = 0; m_un = 0; m_addr = '0;
    endtask

    task automatic idle_cycle(input bit force_clr);
        logic [3:0] e_rc;
        @(negedge clk);
        cpu_write_n = 2'b11;
        cpu_read_n  = 2'b11;
        cpu_addr    = 28'($urandom);
        noise();
        err_clr = force_clr || ($urandom_range(0, 5) == 0);
        #1;
        e_rc = 4'(cpu_read_complete) << m_sel;
        check_all(1'b0, ERRD, 8'hFF, 8'hFF, e_rc);
        if (err_clr) clear_model();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            cpu_addr = 28'($urandom);
            cpu_write_n = 2'($urandom_range(0, 3));
            cpu_read_n  = 2'b11;
            noise();
            err_clr = 1'b0;
            #1;
            check("rst_ready", 32'(cpu_data_ready), 32'h0);
            check("rst_rdata", cpu_data_in, ERRD);
            check("rst_write_n", 32'(ch_write_n), 32'hFF);
            check("rst_read_n", 32'(ch_read_n), 32'hFF);
            check("rst_read_complete", 32'(ch_read_complete), 32'h0);
        end
        clear_model();
        m_sel = 0;
        @(negedge clk);
        rst = 1'b0;
        cpu_write_n = 2'b11;
        cpu_read_n  = 2'b11;
    endtask

    // One CPU transaction; channel `region` answers on request-relative cycle d.
    // Address switches to alt at cycle move_at; rst_at >= 0 aborts with reset.
    task automatic run_txn(input logic [27:0] addr, input bit wr, input logic [1:0] sz,
                           input int d, input logic [31:0] tdata,
                           input int move_at, input logic [27:0] alt, input int rst_at);
        int          region;
        bit          mapped;
        bit          done;
        bit          e_rdy, e_to, e_un;
        logic [31:0] e_data;
        logic [7:0]  e_wn, e_rn;
        logic [3:0]  e_rc;
        logic [27:0] a;
        region = int'(addr[27:25]);
        mapped = (region < NCH);
        a = addr;
        done = 0;
        for (int c = 0; c <= TO + 2 && !done; c++) begin
            @(negedge clk);
            if (c == move_at) a = alt;
            cpu_addr    = a;
            cpu_write_n = wr ? sz : 2'b11;
            cpu_read_n  = wr ? 2'b11 : sz;
            noise();
            err_clr = ($urandom_range(0, 5) == 0);
            if (mapped) begin
                ch_ready[region] = (c == d);
                ch_data_in[32*region +: 32] = tdata;
            end
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                check("abort_ready", 32'(cpu_data_ready), 32'h0);
                check("abort_write_n", 32'(ch_write_n), 32'hFF);
                check("abort_read_n", 32'(ch_read_n), 32'hFF);
                check("abort_read_complete", 32'(ch_read_complete), 32'h0);
                clear_model();
                m_sel = 0;
                @(negedge clk);
                rst = 1'b0;
                cpu_write_n = 2'b11;
                cpu_read_n  = 2'b11;
                err_clr = 1'b0;
                return;
            end
            #1;
            e_rdy = 0; e_to = 0; e_un = 0;
            e_data = ERRD;
            e_wn = 8'hFF;
            e_rn = 8'hFF;
            e_rc = 4'(cpu_read_complete) << m_sel;
            if (mapped) begin
                if (c == d) begin
                    e_rdy = 1;
                    e_data = tdata;
                end else if (c == TO) begin
                    e_rdy = 1;
                    e_to = 1;
                end
                if (!e_to) begin
                    e_wn[2*region +: 2] = cpu_write_n;
                    e_rn[2*region +: 2] = cpu_read_n;
                end
            end else if (c == 1) begin
                e_rdy = 1;
                e_un = 1;
            end
            check_all(e_rdy, e_data, e_wn, e_rn, e_rc);
            if (mapped && c == 0) m_sel = region;
            if (err_clr) clear_model();
            if (e_to) begin m_to = 1; m_addr = a; end
            if (e_un) begin m_un = 1; m_addr = a; end
            done = e_rdy;
        end
        if (!done) begin
            n_chk++;
            n_bad++;
            $display("FAIL txn_end: got no completion want completion");
        end
    endtask

    initial begin
        rst = 1'b1;
        cpu_addr = '0;
        cpu_write_n = 2'b11;
        cpu_read_n = 2'b11;
        cpu_read_complete = 1'b0;
        cpu_data_out = '0;
        ch_ready = '0;
        ch_data_in = '0;
        err_clr = 1'b0;
        m_sel = 0;
        clear_model();
        do_reset(2);
        idle_cycle(0);

        // Region 2 read, ready after 3 cycles
        run_txn(28'h4000010, 0, 2'b10, 3, 32'h12345678, -1, '0, -1);
        idle_cycle(0);
        // Region 1 write; address moves to region 3 mid-transaction
        run_txn(28'h2000020, 1, 2'b00, 4, 32'h0BAD_F00D, 2, 28'h6000020, -1);
        idle_cycle(0);
        // Timeout then explicit clear
        run_txn(28'h2000100, 0, 2'b10, 100, 32'h1, -1, '0, -1);
        idle_cycle(0);
        idle_cycle(1);
        idle_cycle(0);
        // Unmapped region 5
        run_txn(28'hA000000, 0, 2'b10, 0, 32'h2, -1, '0, -1);
        idle_cycle(0);
        // Ready exactly on the timeout cycle, and one past it
        run_txn(28'h0000040, 0, 2'b01, TO, 32'hCAFE_0008, -1, '0, -1);
        idle_cycle(0);
        run_txn(28'h0000044, 1, 2'b01, TO + 1, 32'hCAFE_0009, -1, '0, -1);
        idle_cycle(0);
        // Reset during ACTIVE cycle 2, then a same-cycle completion proves IDLE
        run_txn(28'h2000200, 0, 2'b10, 100, 32'h3, -1, '0, 2);
        idle_cycle(0);
        run_txn(28'h4000300, 0, 2'b10, 0, 32'h5555_AAAA, -1, '0, -1);

        for (int t = 0; t < 80; t++) begin
            logic [27:0] addr;
            int gaps;
            addr = 28'($urandom);
            addr[27:25] = 3'($urandom_range(0, 5));
            run_txn(addr, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    $urandom_range(0, 11), $urandom, $urandom_range(1, 12),
                    28'($urandom), -1);
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) idle_cycle(0);
        end
        idle_cycle(0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
